dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single data-memory bus (request / we_re / mask / address / data, answered by data_valid) between two requesters: instruction fetch (read-only) and the memory stage (load/store).
- Sits between the pipeline and the memory wrapper.
- Allows one outstanding transaction.
- Arbitration is fixed-priority with the memory stage first, plus a starvation guard for fetch and a response timeout.

Parameters:
- DataWidth, 32, width of address and data buses.
- STARVE_LIMIT, 4, consecutive memory-stage grants allowed while if_req waits; the next grant then goes to fetch (range 1..255).
- TIMEOUT, 255, cycles to wait for mem_data_valid before aborting; 0 disables the timeout (range 0..65535).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- if_req  in  1  fetch read request; held with if_addr until if_valid
- if_addr  in  DataWidth  fetch address
- if_valid  out  1  fetch response strobe, one cycle
- if_rdata  out  DataWidth  fetch read data, qualified by if_valid
- ls_req  in  1  memory-stage request; held with its fields until ls_valid
- ls_we  in  1  1 = store, 0 = load
- ls_mask  in  4  byte mask from the memory wrapper
- ls_addr  in  DataWidth  memory-stage address
- ls_wdata  in  DataWidth  store data
- ls_valid  out  1  memory-stage response strobe, one cycle
- ls_rdata  out  DataWidth  load data, qualified by ls_valid
- mem_request  out  1  bus request, registered
- mem_we_re  out  1  1 = write, registered
- mem_mask  out  4  byte mask, registered
- mem_addr  out  DataWidth  bus address, registered
- mem_wdata  out  DataWidth  bus write data, registered
- mem_data_valid  in  1  memory completion strobe
- mem_rdata  in  DataWidth  memory read data
- bus_err  out  1  one-cycle pulse on timeout abort
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: synchronous, active-high, highest priority, effective from any state.
  - State goes to IDLE.
  - mem_request = 0, mem_we_re = 0, mem_mask = 0, mem_addr = 0, mem_wdata = 0.
  - Streak counter and timeout counter = 0.
  - if_valid = ls_valid = bus_err = busy = 0.
  - Reset mid-transaction drops mem_request at that edge; a late mem_data_valid is ignored.
- States: IDLE, BUSY_I, BUSY_D.
- IDLE, sampled at the clock edge:
  - If ls_req and not (if_req and streak == STARVE_LIMIT): go to BUSY_D.
    - Latch mem_addr = ls_addr, mem_wdata = ls_wdata, mem_mask = ls_mask, mem_we_re = ls_we.
    - mem_request <= 1.
    - streak <= streak + 1 if if_req, else 0 (saturates at STARVE_LIMIT).
  - Else if if_req: go to BUSY_I.
    - Latch mem_addr = if_addr, mem_we_re = 0, mem_mask = 4'b1111, mem_wdata = 0.
    - mem_request <= 1, streak <= 0.
  - Else stay in IDLE; mem_request = 0.
- Grant latency: mem_request rises one cycle after the request is sampled in IDLE.
- BUSY_x: mem_* outputs are held stable. The timeout counter increments each cycle.
- Completion: mem_data_valid = 1 while in BUSY_x.
  - That cycle: x_valid = 1 and x_rdata = mem_rdata (combinational pass-through; ls_rdata is defined only for loads).
  - Next edge: state = IDLE, mem_request = 0, mem_we_re = 0, timeout counter = 0.
  - The requester drops or changes its req in the cycle after x_valid. IDLE therefore never re-issues a completed request; back-to-back transactions leave a single idle cycle between them.
- Timeout: TIMEOUT != 0, and the counter reaches TIMEOUT - 1 without mem_data_valid.
  - That cycle: bus_err = 1, x_valid = 1, x_rdata = 0.
  - Next edge: IDLE, as for completion.
  - If mem_data_valid arrives in the same cycle, it wins: normal completion, no bus_err.
- mem_data_valid in IDLE is ignored; no strobes are generated.
- The non-granted requester sees no strobe; it waits with its req held.
- if_valid and ls_valid are never high in the same cycle.
- Stores complete the same way as loads: ls_valid pulses on mem_data_valid.

Test Plan:
1. Reset, then ls_req = 1, ls_we = 0, ls_addr = 0x100, ls_mask = 4'hF. Memory answers mem_rdata = 0xDEADBEEF after 2 cycles → mem_request high from cycle 1 with mem_addr = 0x100, mem_we_re = 0; ls_valid pulses once with ls_rdata = 0xDEADBEEF; mem_request = 0 the next cycle.
2. if_req and ls_req asserted together (ls store, addr 0x20, wdata 0x11223344, mask 4'b0011), 1-cycle memory → data served first with mem_we_re = 1 and mem_mask = 3; fetch granted next, with mem_mask = 4'hF and mem_we_re = 0.
3. if_req held high while ls_req re-asserts continuously for 6 requests, STARVE_LIMIT = 4 → grant order D, D, D, D, I, D, D.
4. TIMEOUT = 8, memory never answers an ls load → bus_err and ls_valid pulse in the 8th BUSY_D cycle with ls_rdata = 0; state returns to IDLE; a subsequent if_req is served normally.
5. rst asserted in the 2nd cycle of BUSY_I, then mem_data_valid pulsed → mem_request = 0 after the reset edge; no if_valid pulse; busy = 0.
6. mem_data_valid pulsed in IDLE with no requests → if_valid, ls_valid and bus_err all stay 0.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the data-memory bus: memory stage (load/store) and instruction fetch.
// Latency: mem_request rises one cycle after a request is sampled in IDLE; response strobes are combinational from mem_data_valid.
// Backpressure: one outstanding transaction; the non-granted requester holds its req until its own strobe.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   if_req/if_addr                - fetch read request (held until if_valid)
//   if_valid/if_rdata             - fetch response strobe and data
//   ls_req/ls_we/ls_mask/ls_addr/ls_wdata - memory-stage request (held until ls_valid)
//   ls_valid/ls_rdata             - memory-stage response strobe and load data
//   mem_request/mem_we_re/mem_mask/mem_addr/mem_wdata - registered bus request to the memory wrapper
//   mem_data_valid/mem_rdata      - memory completion strobe and read data
//   bus_err                       - one-cycle pulse when a transaction is aborted by timeout
//   busy                          - high whenever a transaction is in flight
module dmem_port_arbiter #(
  parameter int DataWidth    = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic                 clk,
  input  logic                 rst,

  input  logic                 if_req,
  input  logic [DataWidth-1:0] if_addr,
  output logic                 if_valid,
  output logic [DataWidth-1:0] if_rdata,

  input  logic                 ls_req,
  input  logic                 ls_we,
  input  logic [3:0]           ls_mask,
  input  logic [DataWidth-1:0] ls_addr,
  input  logic [DataWidth-1:0] ls_wdata,
  output logic                 ls_valid,
  output logic [DataWidth-1:0] ls_rdata,

  output logic                 mem_request,
  output logic                 mem_we_re,
  output logic [3:0]           mem_mask,
  output logic [DataWidth-1:0] mem_addr,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic                 mem_data_valid,
  input  logic [DataWidth-1:0] mem_rdata,

  output logic                 bus_err,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  // Streak counter is 8 bits (limit up to 255), timeout counter 16 bits (limit up to 65535).
  localparam logic [7:0]  STARVE_MAX   = STARVE_LIMIT[7:0];
  localparam bit          TMO_EN       = (TIMEOUT != 0);
  localparam int          TMO_LAST_I   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [15:0] TMO_LAST     = TMO_LAST_I[15:0];

  state_t                 state_q, state_d;
  logic                   mem_request_q, mem_request_d;
  logic                   mem_we_re_q, mem_we_re_d;
  logic [3:0]             mem_mask_q, mem_mask_d;
  logic [DataWidth-1:0]   mem_addr_q, mem_addr_d;
  logic [DataWidth-1:0]   mem_wdata_q, mem_wdata_d;
  logic [7:0]             streak_q, streak_d;
  logic [15:0]            tmo_q, tmo_d;

  logic                   in_busy;
  logic                   tmo_hit;
  logic                   xfer_end;
  logic                   fetch_starved;
  logic [DataWidth-1:0]   rdata_mux;

  assign in_busy  = (state_q == BUSY_I) || (state_q == BUSY_D);

  // Timeout fires in the TIMEOUT-th busy cycle (counter starts at 0 on entry).
  assign tmo_hit  = TMO_EN && in_busy && (tmo_q == TMO_LAST);

  // A real completion in the same cycle as the timeout takes precedence.
  assign xfer_end = in_busy && (mem_data_valid || tmo_hit);

  // Fetch has waited through STARVE_LIMIT consecutive memory-stage grants.
  assign fetch_starved = if_req && (streak_q == STARVE_MAX);

  // Aborted transactions return zero data; both ports share the same mux
  // since only the granted side gets a strobe.
  assign rdata_mux = mem_data_valid ? mem_rdata : '0;

  // Next-state, bus-register and response-strobe logic.
  always_comb begin
    state_d       = state_q;
    mem_request_d = mem_request_q;
    mem_we_re_d   = mem_we_re_q;
    mem_mask_d    = mem_mask_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    streak_d      = streak_q;
    tmo_d         = tmo_q;

    if_valid      = 1'b0;
    ls_valid      = 1'b0;
    bus_err       = 1'b0;
    if_rdata      = '0;
    ls_rdata      = '0;

    case (state_q)
      IDLE: begin
        tmo_d         = '0;
        mem_request_d = 1'b0;
        if (ls_req && !fetch_starved) begin
          state_d       = BUSY_D;
          mem_request_d = 1'b1;
          mem_we_re_d   = ls_we;
          mem_mask_d    = ls_mask;
          mem_addr_d    = ls_addr;
          mem_wdata_d   = ls_wdata;
          // Only count grants that actually made fetch wait.
          if (if_req) begin
            streak_d = (streak_q == STARVE_MAX) ? STARVE_MAX : streak_q + 8'd1;
          end else begin
            streak_d = '0;
          end
        end else if (if_req) begin
          state_d       = BUSY_I;
          mem_request_d = 1'b1;
          mem_we_re_d   = 1'b0;
          mem_mask_d    = 4'b1111;
          mem_addr_d    = if_addr;
          mem_wdata_d   = '0;
          streak_d      = '0;
        end
      end

      BUSY_I, BUSY_D: begin
        if (xfer_end) begin
          state_d       = IDLE;
          mem_request_d = 1'b0;
          mem_we_re_d   = 1'b0;
          tmo_d         = '0;
          bus_err       = !mem_data_valid;
          if (state_q == BUSY_I) begin
            if_valid = 1'b1;
            if_rdata = rdata_mux;
          end else begin
            ls_valid = 1'b1;
            ls_rdata = rdata_mux;
          end
        end else if (tmo_q != 16'hFFFF) begin
          // Saturate so a disabled timeout never wraps.
          tmo_d = tmo_q + 16'd1;
        end
      end

      default: begin
        state_d       = IDLE;
        mem_request_d = 1'b0;
        mem_we_re_d   = 1'b0;
        tmo_d         = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_request_q <= 1'b0;
      mem_we_re_q   <= 1'b0;
      mem_mask_q    <= 4'b0000;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      streak_q      <= '0;
      tmo_q         <= '0;
    end else begin
      state_q       <= state_d;
      mem_request_q <= mem_request_d;
      mem_we_re_q   <= mem_we_re_d;
      mem_mask_q    <= mem_mask_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      streak_q      <= streak_d;
      tmo_q         <= tmo_d;
    end
  end

  assign mem_request = mem_request_q;
  assign mem_we_re   = mem_we_re_q;
  assign mem_mask    = mem_mask_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [DW-1:0] if_addr;
  logic          if_valid;
  logic [DW-1:0] if_rdata;
  logic          ls_req;
  logic          ls_we;
  logic [3:0]    ls_mask;
  logic [DW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_valid;
  logic [DW-1:0] ls_rdata;
  logic          mem_request;
  logic          mem_we_re;
  logic [3:0]    mem_mask;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_data_valid;
  logic [DW-1:0] mem_rdata;
  logic          bus_err;
  logic          busy;

  int n_checks = 0;
  int n_fails  = 0;

  dmem_port_arbiter #(
    .DataWidth   (DW),
    .STARVE_LIMIT(4),
    .TIMEOUT     (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_valid      (if_valid),
    .if_rdata      (if_rdata),
    .ls_req        (ls_req),
    .ls_we         (ls_we),
    .ls_mask       (ls_mask),
    .ls_addr       (ls_addr),
    .ls_wdata      (ls_wdata),
    .ls_valid      (ls_valid),
    .ls_rdata      (ls_rdata),
    .mem_request   (mem_request),
    .mem_we_re     (mem_we_re),
    .mem_mask      (mem_mask),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_data_valid(mem_data_valid),
    .mem_rdata     (mem_rdata),
    .bus_err       (bus_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected grant order with if_req held and ls_req continuous: 1 = data, 0 = fetch.
  logic [6:0] exp_d;
  int         dcount;

  initial begin
    rst = 1'b1; if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0;
    ls_mask = '0; ls_addr = '0; ls_wdata = '0; mem_data_valid = 1'b0; mem_rdata = '0;
    exp_d = 7'b1101111; // index 0 = first grant (LSB)
    dcount = 0;

    // Reset state
    step(); step();
    chk("rst_mem_request", mem_request, 0);
    chk("rst_mem_we_re",   mem_we_re,   0);
    chk("rst_mem_mask",    mem_mask,    0);
    chk("rst_mem_addr",    mem_addr,    0);
    chk("rst_mem_wdata",   mem_wdata,   0);
    chk("rst_busy",        busy,        0);
    chk("rst_strobes",     {if_valid, ls_valid, bus_err}, 0);
    rst = 1'b0;
    step();

    // 1: single load, memory answers in the second busy cycle
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h100; ls_mask = 4'hF;
    step();
    chk("t1_mem_request", mem_request, 1);
    chk("t1_mem_addr",    mem_addr,    32'h100);
    chk("t1_mem_we_re",   mem_we_re,   0);
    chk("t1_busy",        busy,        1);
    chk("t1_no_early_vld", ls_valid,   0);
    step();
    chk("t1_still_wait",  ls_valid,    0);
    mem_data_valid = 1'b1; mem_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_ls_valid",    ls_valid,    1);
    chk("t1_ls_rdata",    ls_rdata,    32'hDEADBEEF);
    chk("t1_if_valid",    if_valid,    0);
    step();
    mem_data_valid = 1'b0; ls_req = 1'b0;
    #1;
    chk("t1_req_drop",    mem_request, 0);
    chk("t1_ls_valid_end", ls_valid,   0);
    chk("t1_idle",        busy,        0);

    // 2: simultaneous fetch and store; store wins, fetch next
    if_req = 1'b1; if_addr = 32'h40;
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = 32'h11223344; ls_mask = 4'b0011;
    step();
    chk("t2_d_addr",  mem_addr,  32'h20);
    chk("t2_d_we",    mem_we_re, 1);
    chk("t2_d_mask",  mem_mask,  4'h3);
    chk("t2_d_wdata", mem_wdata, 32'h11223344);
    mem_data_valid = 1'b1; mem_rdata = 32'h0;
    #1;
    chk("t2_d_valid", {if_valid, ls_valid}, 2'b01);
    step();
    mem_data_valid = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    #1;
    chk("t2_gap", mem_request, 0);
    step();
    chk("t2_i_req",   mem_request, 1);
    chk("t2_i_addr",  mem_addr,  32'h40);
    chk("t2_i_mask",  mem_mask,  4'hF);
    chk("t2_i_we",    mem_we_re, 0);
    chk("t2_i_wdata", mem_wdata, 0);
    mem_data_valid = 1'b1; mem_rdata = 32'hCAFEF00D;
    #1;
    chk("t2_i_valid", {if_valid, ls_valid}, 2'b10);
    chk("t2_i_rdata", if_rdata, 32'hCAFEF00D);
    step();
    mem_data_valid = 1'b0; if_req = 1'b0;
    #1;
    chk("t2_idle", busy, 0);

    // 3: starvation guard, expected order D D D D I D D
    if_req = 1'b1; if_addr = 32'h300;
    ls_req = 1'b1; ls_we = 1'b0; ls_mask = 4'hF; ls_addr = 32'h200;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("t3_grant%0d_addr", i), mem_addr,
          exp_d[i] ? (32'h200 + 32'(dcount)) : 32'h300);
      mem_data_valid = 1'b1; mem_rdata = 32'h1000 + 32'(i);
      #1;
      chk($sformatf("t3_grant%0d_strobe", i), {if_valid, ls_valid},
          exp_d[i] ? 2'b01 : 2'b10);
      step();
      mem_data_valid = 1'b0;
      if (exp_d[i]) begin
        dcount++;
        ls_addr = 32'h200 + 32'(dcount);
      end else begin
        if_addr = 32'h304;
      end
      if (i == 6) begin
        ls_req = 1'b0; if_req = 1'b0;
      end
    end
    #1;
    chk("t3_dcount_idle", {busy, mem_request}, 0);

    // 4: timeout after 8 busy cycles with no answer
    ls_req = 1'b1; ls_addr = 32'h400; mem_rdata = 32'hFFFF0000;
    step();
    for (int k = 1; k < 8; k++) begin
      chk($sformatf("t4_wait%0d", k), {bus_err, ls_valid, if_valid}, 0);
      step();
    end
    chk("t4_bus_err",  bus_err,  1);
    chk("t4_ls_valid", ls_valid, 1);
    chk("t4_ls_rdata", ls_rdata, 0);
    chk("t4_if_valid", if_valid, 0);
    step();
    ls_req = 1'b0;
    #1;
    chk("t4_idle",     {busy, mem_request, bus_err}, 0);
    if_req = 1'b1; if_addr = 32'h500;
    step();
    chk("t4_fetch_addr", mem_addr, 32'h500);
    step();
    mem_data_valid = 1'b1; mem_rdata = 32'h600DF00D;
    #1;
    chk("t4_fetch_valid", {if_valid, bus_err}, 2'b10);
    chk("t4_fetch_rdata", if_rdata, 32'h600DF00D);
    step();
    mem_data_valid = 1'b0; if_req = 1'b0;

    // 4b: completion in the timeout cycle wins
    ls_req = 1'b1; ls_addr = 32'h440;
    step();
    repeat (7) step();
    mem_data_valid = 1'b1; mem_rdata = 32'h5A5A5A5A;
    #1;
    chk("t4b_valid_no_err", {ls_valid, bus_err}, 2'b10);
    chk("t4b_rdata", ls_rdata, 32'h5A5A5A5A);
    step();
    mem_data_valid = 1'b0; ls_req = 1'b0;

    // 5: reset in the second BUSY_I cycle, then a late memory answer
    if_req = 1'b1; if_addr = 32'h600;
    step();
    chk("t5_granted", mem_request, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; if_req = 1'b0; mem_data_valid = 1'b1; mem_rdata = 32'h12345678;
    #1;
    chk("t5_req_dropped", mem_request, 0);
    chk("t5_addr_cleared", mem_addr, 0);
    chk("t5_busy",        busy,     0);
    chk("t5_no_if_valid", if_valid, 0);
    step();
    mem_data_valid = 1'b0;
    #1;
    chk("t5_still_idle", {busy, mem_request}, 0);

    // 6: stray mem_data_valid in IDLE
    mem_data_valid = 1'b1; mem_rdata = 32'hAAAA5555;
    #1;
    chk("t6_strobes", {if_valid, ls_valid, bus_err}, 0);
    step();
    mem_data_valid = 1'b0;
    #1;
    chk("t6_idle", {busy, mem_request}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
